// File: rtl/bsr_row_ptr_fetcher_if.sv
// Row-pointer fetcher bus: control, row_ptr BRAM read port and descriptor stream.
// master = fetcher side, slave = environment side (scheduler, BRAM, sequencer).
interface bsr_row_ptr_fetcher_if #(
   parameter int ADDR_W = 16
);
   logic              start;
   logic [15:0]       num_block_rows;
   logic              row_ptr_en;
   logic [ADDR_W-1:0] row_ptr_addr;
   logic [31:0]       row_ptr_data;
   logic              desc_valid;
   logic              desc_ready;
   logic [15:0]       desc_row;
   logic [31:0]       desc_start;
   logic [31:0]       desc_count;
   logic              desc_last;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      input  start, num_block_rows, row_ptr_data, desc_ready,
      output row_ptr_en, row_ptr_addr, desc_valid, desc_row, desc_start,
             desc_count, desc_last, busy, done, err
   );

   modport slave (
      output start, num_block_rows, row_ptr_data, desc_ready,
      input  row_ptr_en, row_ptr_addr, desc_valid, desc_row, desc_start,
             desc_count, desc_last, busy, done, err
   );
endinterface

// File: rtl/bsr_row_ptr_fetcher.sv
// BSR row-pointer fetcher: walks row_ptr[0..N] once per pass and emits one
// {row, start, count, last} descriptor per block row through a small FIFO.
// Optional build macro BSR_SKIP_EMPTY_ROWS_EN: rows with count==0 are not queued.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start
// RD_FIRST  | read row_ptr[0]
// CAP_FIRST | latch row_ptr[0] as prev_ptr
// RD_NEXT   | read row_ptr[row+1] once the FIFO has room
// CAP_NEXT  | build/push descriptor for row, advance row
// DRAIN     | wait for scheduler to empty the FIFO
// DONE      | one-cycle done pulse
module bsr_row_ptr_fetcher #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   bsr_row_ptr_fetcher_if.master bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE, RD_FIRST, CAP_FIRST, RD_NEXT, CAP_NEXT, DRAIN, DONE
   } state_t;

   state_t            state, state_nxt;
   logic [15:0]       n_rows;
   logic [15:0]       row;
   logic [31:0]       prev_ptr;
   logic              err_q;
   logic [80:0]       mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [PW:0]       count;
   logic              empty, full, push, push_ok, pop;
   logic              last_row, neg_delta;
   logic [31:0]       delta;
   logic [80:0]       push_word;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;

   assign empty     = (count == '0);
   assign full      = (count == DEPTH_C);
   assign pop       = !empty && bus.desc_ready;
   assign push_ok   = push && (!full || pop);
   assign last_row  = (row == n_rows - 16'd1);
   assign neg_delta = (bus.row_ptr_data < prev_ptr);
   assign delta     = neg_delta ? 32'd0 : (bus.row_ptr_data - prev_ptr);
   assign push_word = {row, prev_ptr, delta, last_row};

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state, BRAM read and FIFO push decisions
   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      rd_addr   = '0;
      push      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start)
               state_nxt = (bus.num_block_rows == 16'd0) ? DONE : RD_FIRST;
         end
         RD_FIRST: begin
            rd_en     = 1'b1;
            state_nxt = CAP_FIRST;
         end
         CAP_FIRST: state_nxt = RD_NEXT;
         RD_NEXT: begin
            // no read is ever in flight here, so occupancy alone gates the issue
            if (count < DEPTH_C) begin
               rd_en     = 1'b1;
               rd_addr   = ADDR_W'(row) + ADDR_W'(1);
               state_nxt = CAP_NEXT;
            end
         end
         CAP_NEXT: begin
`ifdef BSR_SKIP_EMPTY_ROWS_EN
            push = (delta != 32'd0);
`else
            push = 1'b1;
`endif
            state_nxt = last_row ? DRAIN : RD_NEXT;
         end
         DRAIN: begin
            if (empty) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // pass bookkeeping: row counter, previous pointer, sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         n_rows   <= '0;
         row      <= '0;
         prev_ptr <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state == IDLE && bus.start) begin
            n_rows   <= bus.num_block_rows;
            row      <= '0;
            prev_ptr <= '0;
            err_q    <= 1'b0;
         end
         if (state == CAP_FIRST) prev_ptr <= bus.row_ptr_data;
         if (state == CAP_NEXT) begin
            prev_ptr <= bus.row_ptr_data;
            row      <= row + 16'd1;
            if (neg_delta) err_q <= 1'b1;
         end
      end
   end

   // FIFO pointers and occupancy; push and pop may coincide even when full
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop)     rd_ptr <= rd_ptr + PW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; contents are don't-care while the FIFO is empty
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_word;
   end

   assign bus.row_ptr_en   = rd_en;
   assign bus.row_ptr_addr = rd_addr;
   assign bus.desc_valid   = !empty;
   assign {bus.desc_row, bus.desc_start, bus.desc_count, bus.desc_last} = mem[rd_ptr];
   assign bus.busy         = (state != IDLE);
   assign bus.done         = (state == DONE);
   assign bus.err          = err_q;
endmodule
